block_copy_ctrl: RTL and testbench
==================================

Name: block_copy_ctrl

Overview:
Memory-to-memory block-copy sequencer for the MiniComputer datapath. On Start, it reads Len words from SrcAddr and writes them to DstAddr over a single req/ack memory port. It owns the source and destination address counters (step-by-ADDR_STEP) and the word counter (parallel-load length, count-up), and sequences them with a small FSM. It sits between the CPU control unit, which issues Start, and the memory arbiter.

Parameters:
ADDR_W, 32, width of the address bus and the address counters
DATA_W, 32, width of the memory data bus
LEN_W, 16, width of the length and word counter
ADDR_STEP, 4, address increment applied per word transferred

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-high reset
Start  in  1  begin a copy; sampled only in IDLE
SrcAddr  in  ADDR_W  source base address; latched on accepted Start
DstAddr  in  ADDR_W  destination base address; latched on accepted Start
Len  in  LEN_W  number of words to copy; latched on accepted Start
MemReq  out  1  memory request; held high until MemAck
MemWe  out  1  1 = write, 0 = read; valid while MemReq is high
MemAddr  out  ADDR_W  current source address (read) or destination address (write)
MemWdata  out  DATA_W  captured read data; driven during write
MemRdata  in  DATA_W  read data; valid in the cycle where MemReq&&MemAck and MemWe=0
MemAck  in  1  transaction complete in this cycle
Busy  out  1  high in RD and WR states
Done  out  1  one-cycle completion pulse
WordCnt  out  LEN_W  number of words fully written in the current or last copy

Behaviour:
- Clock and reset: one clock (Clk). Rst is asynchronous and active-high.
- Reset values: state=IDLE; all address, length, data and count registers = 0. MemReq, MemWe, Busy and Done = 0. MemReq drops immediately when Rst asserts, including mid-transfer.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - Start=1 latches Src, Dst and Len, and clears WordCnt.
  - Next state is RD if Len!=0, else DONE.
  - Start is ignored in every other state.
  - MemAck is ignored in IDLE and DONE.
- RD:
  - Outputs: MemReq=1, MemWe=0, MemAddr=src.
  - On MemAck, MemRdata is captured into the data register and the next state is WR.
  - Without MemAck, the FSM stays in RD with the outputs stable.
- WR:
  - Outputs: MemReq=1, MemWe=1, MemAddr=dst, MemWdata=data register.
  - On MemAck:
    - src += ADDR_STEP and dst += ADDR_STEP, modulo 2^ADDR_W (wrap-around is silent).
    - WordCnt += 1.
    - If WordCnt+1 == Len, the next state is DONE; otherwise RD.
- DONE: Done=1 for exactly one cycle, then IDLE. Busy=0 in DONE.
- Latency: with Start accepted at edge 0 and MemAck tied high, MemReq rises after edge 0. Done is high between edges 2N and 2N+1 (2 cycles per word). With Len=0, Done is high between edges 0 and 1 and no MemReq is issued.
- Registered Mem* outputs: no combinational path from MemAck to MemReq within a cycle. MemReq falls only on the edge after the acknowledged cycle.
- Len=2^LEN_W-1 must complete without WordCnt overflow. WordCnt holds its final value after Done until the next accepted Start.
- A new Start held high through DONE is accepted in the following IDLE cycle.

Optional Feature:
Macro BLKCPY_ABORT_EN.
- Defined:
  - Adds input Abort (1) and output Aborted (1, reset 0).
  - Abort=1 in RD or WR forces DONE on the next edge, even if MemAck is high in that cycle. In that case the current word is not counted and its addresses are not advanced.
  - Aborted is set with entry to DONE, held until the next accepted Start, and cleared on Rst.
  - Abort is ignored in IDLE and DONE.
- Undefined: neither port exists and the FSM has no abort path.

Test Plan:
- Reset mid-copy: Rst pulsed while in WR with MemReq=1 -> MemReq=0 asynchronously, state IDLE, WordCnt=0, no Done pulse.
- Basic copy: Src=0x100, Dst=0x200, Len=3, MemAck tied 1, read data 0xA,0xB,0xC -> writes go to 0x200/0x204/0x208 with 0xA/0xB/0xC. Done is high exactly 6 cycles after Start, and WordCnt=3.
- Zero length: Len=0 with Start -> Done high the next cycle, MemReq never asserted, WordCnt=0.
- Stalled ack: Len=2, MemAck delayed 3 cycles on each transaction -> MemReq/MemAddr/MemWe stay stable while waiting. Total 4 transactions, Done once, WordCnt=2.
- Address wrap and Start while Busy: Src=0xFFFFFFFC, Len=2, with Start re-pulsed mid-copy -> second read at 0x00000000, second Start ignored, single Done.
- (BLKCPY_ABORT_EN) Abort asserted in the second RD of a Len=5 copy -> Done with Aborted=1, WordCnt=1, no further MemReq.

Source files
------------

// File: rtl/block_copy_ctrl_if.sv
// Memory port bundle for block_copy_ctrl: single req/ack channel.
// master = copy controller, slave = memory arbiter side.
interface block_copy_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/block_copy_ctrl.sv
// block_copy_ctrl: memory-to-memory block-copy sequencer.
// Reads i_len words starting at i_src_addr and writes them starting at
// i_dst_addr over one req/ack port, two cycles per word when ack is immediate.
// Optional abort path enabled by defining BLKCPY_ABORT_EN
// (adds i_abort input and o_aborted status output).
module block_copy_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_src_addr,
   input  logic [ADDR_W-1:0] i_dst_addr,
   input  logic [LEN_W-1:0]  i_len,
   block_copy_ctrl_if.master mem,
   output logic              o_busy,
   output logic              o_done,
   output logic [LEN_W-1:0]  o_word_cnt
`ifdef BLKCPY_ABORT_EN
   ,
   input  logic              i_abort,
   output logic              o_aborted
`endif
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_data;

   logic [ADDR_W-1:0] w_src_nxt;
   logic [ADDR_W-1:0] w_dst_nxt;
   logic [LEN_W-1:0]  w_len_nxt;
   logic [LEN_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic [LEN_W-1:0]  w_cnt_inc;

   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic              r_busy;
   logic              r_done;

   logic              w_req_nxt;
   logic              w_we_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;

`ifdef BLKCPY_ABORT_EN
   logic              r_aborted;
   logic              w_aborted_nxt;
`endif

   assign w_cnt_inc = r_cnt + LEN_W'(1);

   // Next-state, datapath and next-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_len_nxt   = r_len;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
`ifdef BLKCPY_ABORT_EN
      w_aborted_nxt = r_aborted;
`endif

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_src_nxt   = i_src_addr;
               w_dst_nxt   = i_dst_addr;
               w_len_nxt   = i_len;
               w_cnt_nxt   = '0;
`ifdef BLKCPY_ABORT_EN
               w_aborted_nxt = 1'b0;
`endif
               w_state_nxt = (i_len != '0) ? S_RD : S_DONE;
            end
         end

         S_RD: begin
`ifdef BLKCPY_ABORT_EN
            if (i_abort) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end else
`endif
            if (mem.ack) begin
               w_data_nxt  = mem.rdata;
               w_state_nxt = S_WR;
            end
         end

         S_WR: begin
`ifdef BLKCPY_ABORT_EN
            if (i_abort) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = S_DONE;
            end else
`endif
            if (mem.ack) begin
               w_src_nxt   = r_src + STEP;
               w_dst_nxt   = r_dst + STEP;
               w_cnt_nxt   = w_cnt_inc;
               w_state_nxt = (w_cnt_inc == r_len) ? S_DONE : S_RD;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register alongside it
      w_req_nxt  = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
      w_busy_nxt = w_req_nxt;
      w_we_nxt   = (w_state_nxt == S_WR);
      w_addr_nxt = (w_state_nxt == S_WR) ? w_dst_nxt : w_src_nxt;
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
`ifdef BLKCPY_ABORT_EN
         r_aborted <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_len   <= w_len_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
`ifdef BLKCPY_ABORT_EN
         r_aborted <= w_aborted_nxt;
`endif
      end
   end

   // Registered memory-port and status outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_req  <= 1'b0;
         r_we   <= 1'b0;
         r_addr <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_req  <= w_req_nxt;
         r_we   <= w_we_nxt;
         r_addr <= w_addr_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign mem.req    = r_req;
   assign mem.we     = r_we;
   assign mem.addr   = r_addr;
   assign mem.wdata  = r_data;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_word_cnt = r_cnt;
`ifdef BLKCPY_ABORT_EN
   assign o_aborted  = r_aborted;
`endif

endmodule

// File: tb/tb_block_copy_ctrl.sv
// Self-checking bench for block_copy_ctrl: stimulus pushes expected memory
// transactions and completion events into queues; a negedge memory model /
// monitor acknowledges requests and pops/compares as the DUT presents them.
module tb_block_copy_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 16;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   typedef struct packed {
      logic [LW-1:0] cnt;
      logic          ab;
   } done_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] src_a;
   logic [AW-1:0] dst_a;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic [LW-1:0] wcnt;
`ifdef BLKCPY_ABORT_EN
   logic          abort;
   logic          aborted;
`endif

   block_copy_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   block_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STEP(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_src_addr (src_a),
      .i_dst_addr (dst_a),
      .i_len      (len),
      .mem        (mem_if),
      .o_busy     (busy),
      .o_done     (done),
      .o_word_cnt (wcnt)
`ifdef BLKCPY_ABORT_EN
      ,
      .i_abort    (abort),
      .o_aborted  (aborted)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_seen = 0;
   int done_cyc = 0;
   int max_dly = 0;
   bit fixed_dly = 1'b0;
   int wait_left = 0;
   bit pending = 1'b0;
   logic [AW-1:0] hold_addr;
   logic          hold_we;

   txn_t  exp_q[$];
   done_t done_q[$];
   logic [DW-1:0] mem_img [logic [AW-1:0]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   // Reference model: a copy of l words is l reads then writes at stepped addresses
   task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
      done_t dn;
      for (int i = 0; i < int'(l); i++) begin
         logic [AW-1:0] ra;
         logic [AW-1:0] wa;
         ra = s + AW'(4 * i);
         wa = d + AW'(4 * i);
         exp_q.push_back('{we: 1'b0, addr: ra, data: '0});
         exp_q.push_back('{we: 1'b1, addr: wa, data: rd_val(ra)});
      end
      dn.cnt = l;
      dn.ab  = 1'b0;
      done_q.push_back(dn);
   endtask

   always @(posedge clk) cyc++;

   // Memory model + scoreboard monitor, evaluated mid-cycle
   always @(negedge clk) begin
      bit skip;
      txn_t e;
      done_t dn;
      if (rst) begin
         mem_if.ack = 1'b0;
         pending    = 1'b0;
      end else begin
         mem_if.ack   = 1'b0;
         mem_if.rdata = $urandom;
`ifdef BLKCPY_ABORT_EN
         skip = abort;
`else
         skip = 1'b0;
`endif
         if (mem_if.req) begin
            if (!pending) begin
               pending   = 1'b1;
               hold_addr = mem_if.addr;
               hold_we   = mem_if.we;
               wait_left = fixed_dly ? max_dly : int'($urandom_range(max_dly, 0));
            end else begin
               chk("stall_addr", 64'(mem_if.addr), 64'(hold_addr));
               chk("stall_we", 64'(mem_if.we), 64'(hold_we));
            end
            if (wait_left == 0) begin
               mem_if.ack = 1'b1;
               pending    = 1'b0;
               if (!mem_if.we) mem_if.rdata = rd_val(mem_if.addr);
               if (!skip) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL unexpected_txn: got we=%0b addr=0x%0h expected none",
                              mem_if.we, mem_if.addr);
                  end else begin
                     e = exp_q.pop_front();
                     chk("txn_we", 64'(mem_if.we), 64'(e.we));
                     chk("txn_addr", 64'(mem_if.addr), 64'(e.addr));
                     if (e.we) chk("txn_wdata", 64'(mem_if.wdata), 64'(e.data));
                  end
               end
            end else begin
               wait_left--;
            end
         end
         if (done) begin
            done_seen++;
            done_cyc = cyc;
            chk("done_busy_low", 64'(busy), 64'd0);
            if (done_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
               dn = done_q.pop_front();
               chk("done_wordcnt", 64'(wcnt), 64'(dn.cnt));
`ifdef BLKCPY_ABORT_EN
               chk("done_aborted", 64'(aborted), 64'(dn.ab));
`endif
            end
         end
      end
   end

   task automatic wait_done(input int target, input int budget);
      for (int k = 0; k < budget && done_seen < target; k++) @(posedge clk);
      if (done_seen < target) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got %0d done pulses expected %0d", done_seen, target);
      end
   endtask

   task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [LW-1:0] l, input bit chk_lat);
      int t0;
      int tgt;
      tgt = done_seen + 1;
      @(negedge clk);
      start = 1'b1;
      src_a = s;
      dst_a = d;
      len   = l;
      push_copy(s, d, l);
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0;
      src_a = $urandom;
      dst_a = $urandom;
      len   = LW'($urandom);
      chk("busy_after_start", 64'(busy), 64'(l != '0));
      wait_done(tgt, 40 * (int'(l) + 2) * (max_dly + 1));
      if (chk_lat) chk("done_latency", 64'(done_cyc - t0), 64'(2 * int'(l)));
      repeat (2) @(negedge clk);
      chk("wordcnt_hold", 64'(wcnt), 64'(l));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int tgt;
      rst   = 1'b1;
      start = 1'b0;
      src_a = '0;
      dst_a = '0;
      len   = '0;
`ifdef BLKCPY_ABORT_EN
      abort = 1'b0;
`endif
      mem_if.ack   = 1'b0;
      mem_if.rdata = '0;
      #1;
      chk("rst_req", 64'(mem_if.req), 64'd0);
      chk("rst_we", 64'(mem_if.we), 64'd0);
      chk("rst_addr", 64'(mem_if.addr), 64'd0);
      chk("rst_wdata", 64'(mem_if.wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wordcnt", 64'(wcnt), 64'd0);
`ifdef BLKCPY_ABORT_EN
      chk("rst_aborted", 64'(aborted), 64'd0);
`endif
      #22 rst = 1'b0;

      // Basic copy with immediate ack and known source data
      mem_img[32'h100] = 32'hA;
      mem_img[32'h104] = 32'hB;
      mem_img[32'h108] = 32'hC;
      max_dly = 0;
      fixed_dly = 1'b0;
      run_copy(32'h100, 32'h200, 16'd3, 1'b1);

      // Zero length: immediate Done, no request
      run_copy(32'h300, 32'h400, 16'd0, 1'b1);
      chk("zero_len_no_req", 64'(mem_if.req), 64'd0);

      // Stalled ack: three wait cycles per transaction
      max_dly = 3;
      fixed_dly = 1'b1;
      run_copy(32'h1000, 32'h2000, 16'd2, 1'b0);
      fixed_dly = 1'b0;

      // Address wrap with a Start re-pulsed mid-copy
      max_dly = 1;
      tgt = done_seen + 1;
      @(negedge clk);
      start = 1'b1;
      src_a = 32'hFFFF_FFFC;
      dst_a = 32'h0000_5000;
      len   = 16'd2;
      push_copy(32'hFFFF_FFFC, 32'h0000_5000, 16'd2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      src_a = 32'h7000;
      dst_a = 32'h8000;
      len   = 16'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(tgt, 200);
      repeat (6) @(negedge clk);
      chk("wrap_single_done", 64'(done_seen), 64'(tgt));
      chk("wrap_wordcnt", 64'(wcnt), 64'd2);

      // Start held high through DONE is accepted in the following IDLE cycle
      max_dly = 0;
      tgt = done_seen + 2;
      @(negedge clk);
      start = 1'b1;
      src_a = 32'h40;
      dst_a = 32'h80;
      len   = 16'd1;
      push_copy(32'h40, 32'h80, 16'd1);
      @(posedge clk);
      #1;
      src_a = 32'hC0;
      dst_a = 32'hE0;
      len   = 16'd2;
      push_copy(32'hC0, 32'hE0, 16'd2);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done_seen >= tgt - 1 && busy) break;
      end
      chk("held_start_reaccept", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done(tgt, 100);

      // Randomized copies with random ack delays
      for (int r = 0; r < 15; r++) begin
         max_dly = int'($urandom_range(3, 0));
         run_copy($urandom, $urandom, LW'($urandom_range(6, 0)), max_dly == 0);
      end

      // Asynchronous reset while a write request is outstanding
      max_dly = 1;
      tgt = done_seen;
      @(negedge clk);
      start = 1'b1;
      src_a = 32'h9000;
      dst_a = 32'hA000;
      len   = 16'd4;
      push_copy(32'h9000, 32'hA000, 16'd4);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (mem_if.req && mem_if.we && wcnt >= 16'd1) break;
      end
      chk("pre_reset_in_wr", 64'(mem_if.req && mem_if.we), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req", 64'(mem_if.req), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_wordcnt", 64'(wcnt), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      exp_q.delete();
      done_q.delete();
      @(negedge clk);
      #3 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_no_done", 64'(done_seen), 64'(tgt));
      chk("rst_idle_req", 64'(mem_if.req), 64'd0);

`ifdef BLKCPY_ABORT_EN
      // Abort during the second read of a five-word copy
      begin
         done_t dn;
         max_dly = 0;
         tgt = done_seen + 1;
         @(negedge clk);
         start = 1'b1;
         src_a = 32'h600;
         dst_a = 32'h700;
         len   = 16'd5;
         exp_q.push_back('{we: 1'b0, addr: 32'h600, data: '0});
         exp_q.push_back('{we: 1'b1, addr: 32'h700, data: rd_val(32'h600)});
         dn.cnt = 16'd1;
         dn.ab  = 1'b1;
         done_q.push_back(dn);
         @(posedge clk);
         #1;
         start = 1'b0;
         for (int k = 0; k < 20; k++) begin
            if (mem_if.req && !mem_if.we && wcnt == 16'd1) break;
            @(posedge clk);
            #1;
         end
         abort = 1'b1;
         @(posedge clk);
         #1;
         abort = 1'b0;
         wait_done(tgt, 10);
         repeat (4) @(negedge clk);
         chk("abort_no_req", 64'(mem_if.req), 64'd0);
         chk("abort_held", 64'(aborted), 64'd1);
         chk("abort_wordcnt", 64'(wcnt), 64'd1);
         run_copy(32'h610, 32'h710, 16'd1, 1'b1);
         chk("abort_cleared", 64'(aborted), 64'd0);
      end
`endif

      repeat (3) @(negedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("done_q_drained", 64'(done_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
